// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
// Bundles the two private cache bus ports and the shared memory port that
// the arbiter sits between.
//   c0_* / c1_* : per-cache rd/wr/addr/dout requests, din/done responses
//   mem_*       : shared memory strobes, address, write data, read data, done
// Modports:
//   master : the arbiter; drives memory strobes and cache responses
//   slave  : the environment (caches + memory); drives requests and memory
//            responses
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              c0_bus_rd;
  logic              c0_bus_wr;
  logic [ADDR_W-1:0] c0_bus_addr;
  logic [DATA_W-1:0] c0_bus_dout;
  logic [DATA_W-1:0] c0_bus_din;
  logic              c0_bus_done;

  logic              c1_bus_rd;
  logic              c1_bus_wr;
  logic [ADDR_W-1:0] c1_bus_addr;
  logic [DATA_W-1:0] c1_bus_dout;
  logic [DATA_W-1:0] c1_bus_din;
  logic              c1_bus_done;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  modport master (
    input  c0_bus_rd, c0_bus_wr, c0_bus_addr, c0_bus_dout,
    output c0_bus_din, c0_bus_done,
    input  c1_bus_rd, c1_bus_wr, c1_bus_addr, c1_bus_dout,
    output c1_bus_din, c1_bus_done,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_done
  );

  modport slave (
    output c0_bus_rd, c0_bus_wr, c0_bus_addr, c0_bus_dout,
    input  c0_bus_din, c0_bus_done,
    output c1_bus_rd, c1_bus_wr, c1_bus_addr, c1_bus_dout,
    input  c1_bus_din, c1_bus_done,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_done
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Lets two cache controllers share one memory bus. The memory port is granted
// to one cache at a time with round-robin priority, held until the memory
// signals done, and reclaimed by a watchdog if the memory hangs.
// Ports:
//   clk         : clock, all state on rising edge
//   reset       : synchronous, active-high
//   bus         : cache and memory handshake signals (master side)
//   grant       : one-hot current owner {c1,c0}, 00 when idle
//   timeout_err : sticky watchdog-expiry flag, cleared only by reset
module mem_bus_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_bus_arbiter_if.master        bus,
  output logic [1:0]               grant,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // TIMEOUT of 0 turns the watchdog off entirely.
  localparam bit       WDOG_EN   = (TIMEOUT != 0);
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last;
  logic [7:0] wdog;

  logic req0;
  logic req1;
  logic owner_req;
  logic wdog_expire;

  assign req0 = bus.c0_bus_rd | bus.c0_bus_wr;
  assign req1 = bus.c1_bus_rd | bus.c1_bus_wr;

  assign owner_req = (state == OWN1) ? req1 : req0;

  // A completion in the expiry cycle wins, so expiry requires mem_done low.
  assign wdog_expire = WDOG_EN && (wdog == WDOG_LAST) && !bus.mem_done;

  // Read data is broadcast; only the done strobe tells a cache it is theirs.
  assign bus.c0_bus_din = bus.mem_rdata;
  assign bus.c1_bus_din = bus.mem_rdata;

  // Route the owner's request straight to memory and the memory's done
  // straight back to the owner, so a completion costs no extra cycle.
  always_comb begin
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = {ADDR_W{1'b0}};
    bus.mem_wdata   = {DATA_W{1'b0}};
    bus.c0_bus_done = 1'b0;
    bus.c1_bus_done = 1'b0;
    grant           = 2'b00;
    case (state)
      OWN0: begin
        bus.mem_rd      = bus.c0_bus_rd;
        bus.mem_wr      = bus.c0_bus_wr;
        bus.mem_addr    = bus.c0_bus_addr;
        bus.mem_wdata   = bus.c0_bus_dout;
        bus.c0_bus_done = bus.mem_done;
        grant           = 2'b01;
      end
      OWN1: begin
        bus.mem_rd      = bus.c1_bus_rd;
        bus.mem_wr      = bus.c1_bus_wr;
        bus.mem_addr    = bus.c1_bus_addr;
        bus.mem_wdata   = bus.c1_bus_dout;
        bus.c1_bus_done = bus.mem_done;
        grant           = 2'b10;
      end
      default: begin
      end
    endcase
  end

  // Ownership FSM. Every grant passes through IDLE, which is where the
  // watchdog is cleared, so it always starts counting from zero on entry.
  // On a tie the port that was not granted last wins; last resets to 1 so
  // cache 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      wdog        <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= 8'd0;
          if (req0 && (!req1 || last)) begin
            state <= OWN0;
            last  <= 1'b0;
          end else if (req1) begin
            state <= OWN1;
            last  <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          if (bus.mem_done) begin
            state <= IDLE;
            wdog  <= 8'd0;
          end else if (wdog_expire) begin
            state       <= IDLE;
            wdog        <= 8'd0;
            timeout_err <= 1'b1;
          end else if (!owner_req) begin
            state <= IDLE;
            wdog  <= 8'd0;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          wdog  <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed scenarios for reset, single requester, tie, fairness, write-back
// then fetch, watchdog and mid-grant reset, followed by a randomized run
// checked cycle by cycle against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

  localparam int TO = 8;

  logic       clk;
  logic       reset;
  logic [1:0] grant;
  logic       timeout_err;

  int tests_run;
  int tests_failed;

  mem_bus_arbiter_if #(.ADDR_W(5), .DATA_W(16)) bus ();

  mem_bus_arbiter #(
    .ADDR_W (5),
    .DATA_W (16),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {grant, rd, wr, addr, wdata, done0, done1, err}.
  function automatic logic [27:0] obs();
    return {grant, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata,
            bus.c0_bus_done, bus.c1_bus_done, timeout_err};
  endfunction

  function automatic logic [27:0] pack(input logic [1:0] g, input logic rd, input logic wr,
                                       input logic [4:0] a, input logic [15:0] d,
                                       input logic d0, input logic d1, input logic err);
    return {g, rd, wr, a, d, d0, d1, err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.c0_bus_rd   = 1'b0;
    bus.c0_bus_wr   = 1'b0;
    bus.c0_bus_addr = 5'h00;
    bus.c0_bus_dout = 16'h0000;
    bus.c1_bus_rd   = 1'b0;
    bus.c1_bus_wr   = 1'b0;
    bus.c1_bus_addr = 5'h00;
    bus.c1_bus_dout = 16'h0000;
    bus.mem_rdata   = 16'h0000;
    bus.mem_done    = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] want;
    clear_inputs();
    reset = 1'b1;
    bus.c0_bus_rd   = 1'b1;
    bus.c0_bus_addr = 5'h1F;
    bus.c1_bus_wr   = 1'b1;
    bus.c1_bus_dout = 16'hFFFF;
    bus.mem_done    = 1'b1;
    tick();
    tick();
    want = '0;
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", obs(), want);
    end
    reset = 1'b0;
    bus.c0_bus_rd = 1'b0;
    bus.c1_bus_wr = 1'b0;
    #1;
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL idle_stray_done: got %h expected %h", obs(), want);
    end
    tick();
    bus.mem_done = 1'b0;
    #1;
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL idle_stays: got %h expected %h", obs(), want);
    end
  endtask

  task automatic test_single();
    logic [27:0] want;
    do_reset();
    bus.c0_bus_rd   = 1'b1;
    bus.c0_bus_addr = 5'h0A;
    #1;
    want = '0;
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL single_latency: got %h expected %h", obs(), want);
    end
    tick();
    want = pack(2'b01, 1'b1, 1'b0, 5'h0A, 16'h0000, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL single_grant: got %h expected %h", obs(), want);
    end
    tick();
    tick();
    bus.mem_rdata = 16'hBEEF;
    bus.mem_done  = 1'b1;
    #1;
    want = pack(2'b01, 1'b1, 1'b0, 5'h0A, 16'h0000, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL single_done: got %h expected %h", obs(), want);
    end
    tests_run++;
    if (bus.c0_bus_din !== 16'hBEEF) begin
      tests_failed++;
      $display("[TB] FAIL single_din: got %h expected beef", bus.c0_bus_din);
    end
    tick();
    bus.c0_bus_rd = 1'b0;
    bus.mem_done  = 1'b0;
    #1;
    want = '0;
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL single_release: got %h expected %h", obs(), want);
    end
  endtask

  task automatic test_tie();
    logic [27:0] want;
    do_reset();
    bus.c0_bus_wr   = 1'b1;
    bus.c0_bus_addr = 5'h03;
    bus.c0_bus_dout = 16'h1234;
    bus.c1_bus_rd   = 1'b1;
    bus.c1_bus_addr = 5'h11;
    tick();
    want = pack(2'b01, 1'b0, 1'b1, 5'h03, 16'h1234, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL tie_first: got %h expected %h", obs(), want);
    end
    tick();
    bus.mem_done = 1'b1;
    #1;
    want = pack(2'b01, 1'b0, 1'b1, 5'h03, 16'h1234, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL tie_first_done: got %h expected %h", obs(), want);
    end
    tick();
    bus.c0_bus_wr = 1'b0;
    bus.mem_done  = 1'b0;
    #1;
    want = '0;
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL tie_gap: got %h expected %h", obs(), want);
    end
    tick();
    want = pack(2'b10, 1'b1, 1'b0, 5'h11, 16'h0000, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL tie_second: got %h expected %h", obs(), want);
    end
    bus.mem_done = 1'b1;
    #1;
    want = pack(2'b10, 1'b1, 1'b0, 5'h11, 16'h0000, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL tie_second_done: got %h expected %h", obs(), want);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_fairness();
    logic [27:0] want;
    logic [1:0]  g;
    logic [4:0]  a;
    do_reset();
    bus.c0_bus_rd   = 1'b1;
    bus.c0_bus_addr = 5'h01;
    bus.c1_bus_rd   = 1'b1;
    bus.c1_bus_addr = 5'h02;
    for (int i = 0; i < 6; i++) begin
      g = (i % 2 == 0) ? 2'b01 : 2'b10;
      a = (i % 2 == 0) ? 5'h01 : 5'h02;
      tick();
      want = pack(g, 1'b1, 1'b0, a, 16'h0000, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (obs() !== want) begin
        tests_failed++;
        $display("[TB] FAIL fair_grant[%0d]: got %h expected %h", i, obs(), want);
      end
      tick();
      bus.mem_done = 1'b1;
      #1;
      want = pack(g, 1'b1, 1'b0, a, 16'h0000, g[0], g[1], 1'b0);
      tests_run++;
      if (obs() !== want) begin
        tests_failed++;
        $display("[TB] FAIL fair_done[%0d]: got %h expected %h", i, obs(), want);
      end
      tick();
      bus.mem_done = 1'b0;
      #1;
      want = '0;
      tests_run++;
      if (obs() !== want) begin
        tests_failed++;
        $display("[TB] FAIL fair_gap[%0d]: got %h expected %h", i, obs(), want);
      end
    end
    clear_inputs();
  endtask

  task automatic test_wb_fetch();
    logic [27:0] want;
    do_reset();
    bus.c0_bus_wr   = 1'b1;
    bus.c0_bus_addr = 5'h04;
    bus.c0_bus_dout = 16'hAAAA;
    tick();
    bus.c1_bus_rd   = 1'b1;
    bus.c1_bus_addr = 5'h15;
    #1;
    want = pack(2'b01, 1'b0, 1'b1, 5'h04, 16'hAAAA, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL wbf_wr_grant: got %h expected %h", obs(), want);
    end
    tick();
    bus.mem_done = 1'b1;
    #1;
    want = pack(2'b01, 1'b0, 1'b1, 5'h04, 16'hAAAA, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL wbf_wr_done: got %h expected %h", obs(), want);
    end
    tick();
    bus.mem_done  = 1'b0;
    bus.c0_bus_wr = 1'b0;
    bus.c0_bus_rd = 1'b1;
    #1;
    want = '0;
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL wbf_gap: got %h expected %h", obs(), want);
    end
    tick();
    want = pack(2'b10, 1'b1, 1'b0, 5'h15, 16'h0000, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL wbf_c1_grant: got %h expected %h", obs(), want);
    end
    bus.mem_done = 1'b1;
    #1;
    want = pack(2'b10, 1'b1, 1'b0, 5'h15, 16'h0000, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL wbf_c1_done: got %h expected %h", obs(), want);
    end
    tick();
    bus.mem_done  = 1'b0;
    bus.c1_bus_rd = 1'b0;
    #1;
    want = '0;
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL wbf_gap2: got %h expected %h", obs(), want);
    end
    tick();
    want = pack(2'b01, 1'b1, 1'b0, 5'h04, 16'hAAAA, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL wbf_fetch_grant: got %h expected %h", obs(), want);
    end
    bus.mem_done = 1'b1;
    #1;
    want = pack(2'b01, 1'b1, 1'b0, 5'h04, 16'hAAAA, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL wbf_fetch_done: got %h expected %h", obs(), want);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_watchdog();
    logic [27:0] want;
    // Done arriving in the last allowed cycle must win over the watchdog.
    do_reset();
    bus.c0_bus_rd   = 1'b1;
    bus.c0_bus_addr = 5'h06;
    tick();
    for (int k = 0; k < TO - 1; k++) tick();
    bus.mem_done = 1'b1;
    #1;
    want = pack(2'b01, 1'b1, 1'b0, 5'h06, 16'h0000, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL wdog_edge_done: got %h expected %h", obs(), want);
    end
    tick();
    bus.mem_done  = 1'b0;
    bus.c0_bus_rd = 1'b0;
    #1;
    want = '0;
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL wdog_edge_no_err: got %h expected %h", obs(), want);
    end
    // Hung memory: the grant is reclaimed after TO cycles.
    do_reset();
    bus.c1_bus_rd   = 1'b1;
    bus.c1_bus_addr = 5'h07;
    tick();
    for (int k = 0; k < TO; k++) begin
      want = pack(2'b10, 1'b1, 1'b0, 5'h07, 16'h0000, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (obs() !== want) begin
        tests_failed++;
        $display("[TB] FAIL wdog_hold[%0d]: got %h expected %h", k, obs(), want);
      end
      tick();
    end
    bus.c1_bus_rd   = 1'b0;
    bus.c0_bus_rd   = 1'b1;
    bus.c0_bus_addr = 5'h02;
    #1;
    want = pack(2'b00, 1'b0, 1'b0, 5'h00, 16'h0000, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL wdog_expired: got %h expected %h", obs(), want);
    end
    tick();
    want = pack(2'b01, 1'b1, 1'b0, 5'h02, 16'h0000, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL wdog_after_grant: got %h expected %h", obs(), want);
    end
    bus.mem_done = 1'b1;
    #1;
    want = pack(2'b01, 1'b1, 1'b0, 5'h02, 16'h0000, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL wdog_after_done: got %h expected %h", obs(), want);
    end
    tick();
    bus.c0_bus_rd = 1'b0;
    bus.mem_done  = 1'b0;
    #1;
    want = pack(2'b00, 1'b0, 1'b0, 5'h00, 16'h0000, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL wdog_sticky: got %h expected %h", obs(), want);
    end
  endtask

  // Entered straight after the watchdog scenario, so the error flag is set.
  task automatic test_reset_mid();
    logic [27:0] want;
    bus.c0_bus_rd   = 1'b1;
    bus.c0_bus_addr = 5'h09;
    bus.c0_bus_dout = 16'h5555;
    tick();
    want = pack(2'b01, 1'b1, 1'b0, 5'h09, 16'h5555, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_grant: got %h expected %h", obs(), want);
    end
    reset = 1'b1;
    tick();
    want = '0;
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_cleared: got %h expected %h", obs(), want);
    end
    reset = 1'b0;
    bus.c1_bus_rd   = 1'b1;
    bus.c1_bus_addr = 5'h1C;
    tick();
    want = pack(2'b01, 1'b1, 1'b0, 5'h09, 16'h5555, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (obs() !== want) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_tie: got %h expected %h", obs(), want);
    end
    tick();
    clear_inputs();
  endtask

  // Randomized traffic against a transaction-level model: an owner index,
  // the last winner, and how long the current owner has waited.
  task automatic test_random();
    logic [27:0] want;
    logic        c_rd[2];
    logic        c_wr[2];
    logic [4:0]  c_addr[2];
    logic [15:0] c_dout[2];
    bit          act[2];
    int          m_owner;
    bit          m_last;
    int          m_waited;
    int          m_lat;
    logic        m_err;
    logic        mdone;
    logic        req0;
    logic        req1;
    logic [15:0] rdata;
    int          kind;
    int          o;
    do_reset();
    m_owner  = -1;
    m_last   = 1'b1;
    m_waited = 0;
    m_lat    = 0;
    m_err    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      act[k]    = 1'b0;
      c_rd[k]   = 1'b0;
      c_wr[k]   = 1'b0;
      c_addr[k] = 5'h00;
      c_dout[k] = 16'h0000;
    end
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!act[k]) begin
          c_rd[k] = 1'b0;
          c_wr[k] = 1'b0;
          if ($urandom_range(0, 3) == 0) begin
            act[k]    = 1'b1;
            kind      = $urandom_range(0, 4);
            c_rd[k]   = (kind < 2) || (kind == 4);
            c_wr[k]   = (kind >= 2);
            c_addr[k] = 5'($urandom);
            c_dout[k] = 16'($urandom);
          end
        end else if ($urandom_range(0, 63) == 0) begin
          act[k]  = 1'b0;
          c_rd[k] = 1'b0;
          c_wr[k] = 1'b0;
        end
      end
      bus.c0_bus_rd   = c_rd[0];
      bus.c0_bus_wr   = c_wr[0];
      bus.c0_bus_addr = c_addr[0];
      bus.c0_bus_dout = c_dout[0];
      bus.c1_bus_rd   = c_rd[1];
      bus.c1_bus_wr   = c_wr[1];
      bus.c1_bus_addr = c_addr[1];
      bus.c1_bus_dout = c_dout[1];
      rdata = 16'($urandom);
      mdone = (m_owner >= 0) ? (m_waited >= m_lat) : ($urandom_range(0, 7) == 0);
      bus.mem_rdata = rdata;
      bus.mem_done  = mdone;
      #1;
      o = m_owner;
      if (o < 0)
        want = pack(2'b00, 1'b0, 1'b0, 5'h00, 16'h0000, 1'b0, 1'b0, m_err);
      else
        want = pack((o == 1) ? 2'b10 : 2'b01, c_rd[o], c_wr[o], c_addr[o], c_dout[o],
                    (o == 0) && mdone, (o == 1) && mdone, m_err);
      tests_run++;
      if (obs() !== want || bus.c0_bus_din !== rdata || bus.c1_bus_din !== rdata) begin
        tests_failed++;
        $display("[TB] FAIL random[%0d]: got %h din %h/%h expected %h din %h",
                 n, obs(), bus.c0_bus_din, bus.c1_bus_din, want, rdata);
      end
      req0 = c_rd[0] | c_wr[0];
      req1 = c_rd[1] | c_wr[1];
      if (o < 0) begin
        if (req0 || req1) begin
          if (req0 && req1) m_owner = m_last ? 0 : 1;
          else              m_owner = req0 ? 0 : 1;
          m_last   = (m_owner == 1);
          m_waited = 0;
          m_lat    = $urandom_range(0, 4);
        end
      end else if (mdone) begin
        act[o]  = 1'b0;
        m_owner = -1;
      end else begin
        m_waited++;
        if (m_waited >= TO) begin
          m_owner = -1;
          m_err   = 1'b1;
        end else if (!((o == 0) ? req0 : req1)) begin
          m_owner = -1;
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_wb_fetch();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter that lets two cache controllers share one memory bus. Each cache sees a private bus port with the usual rd/wr/addr/dout/din/done handshake. The arbiter grants the single memory port to one cache at a time, using round-robin priority. It holds the grant until the memory signals done, and it recovers from a hung memory through a watchdog timeout.

## Interface
- ADDR_W, 5, bus block address width
- DATA_W, 16, bus data width (one cache block)
- TIMEOUT, 64, max cycles a grant may wait for mem_done; 0 disables watchdog; legal 0..255

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- c0_bus_rd, c1_bus_rd  in  1  cache x read (fetch) request, held until cx_bus_done
- c0_bus_wr, c1_bus_wr  in  1  cache x write-back request, held until cx_bus_done
- c0_bus_addr, c1_bus_addr  in  ADDR_W  cache x block address
- c0_bus_dout, c1_bus_dout  in  DATA_W  cache x write data
- c0_bus_din, c1_bus_din  out  DATA_W  read data to cache x (= mem_rdata, unconditionally)
- c0_bus_done, c1_bus_done  out  1  completion to cache x
- mem_rd, mem_wr  out  1  memory strobes
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_done  in  1  memory completion, one-cycle pulse
- grant  out  2  one-hot current owner ({c1,c0}); 00 when idle
- timeout_err  out  1  sticky, set on watchdog expiry, cleared only by reset

## Operation
- reqx = cx_bus_rd | cx_bus_wr.
- States:
  - IDLE: no owner.
  - OWN0: cache 0 owns the memory port.
  - OWN1: cache 1 owns the memory port.
- Register `last` (1 bit) holds the most recently granted port.
- IDLE transitions:
  - Only req0 → OWN0, last←0.
  - Only req1 → OWN1, last←1.
  - Both → the port ≠ last, and last is updated to it.
  - Neither → stay in IDLE.
- OWNx routing (all combinational from the state):
  - mem_rd=cx_bus_rd, mem_wr=cx_bus_wr, mem_addr=cx_bus_addr, mem_wdata=cx_bus_dout.
  - cx_bus_done=mem_done; the other port's done=0.
- OWNx exits:
  - mem_done=1 → IDLE.
  - reqx drops before done → IDLE, no done delivered.
  - Watchdog: counter wdog (8 bits) clears on entry to OWNx and increments each OWNx cycle with mem_done=0. If TIMEOUT≠0 and wdog==TIMEOUT-1 with mem_done=0 → IDLE, timeout_err←1, no done delivered.
- mem_done in the same cycle as watchdog expiry: done wins; no error.
- mem_done while IDLE: ignored, no done to either cache.
- rd and wr both high from the owner: both forwarded unchanged; no arbitration effect.
- Outputs in IDLE and during/after reset: mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, c0_bus_done=0, c1_bus_done=0, grant=00.
- Reset values: state=IDLE, last=1 (so cache 0 wins the first tie), wdog=0, timeout_err=0.

## Timing
- Request seen in IDLE during cycle t → grant and mem strobes valid from cycle t+1. Arbitration latency is 1 cycle.
- mem_done in cycle u → cx_bus_done in the same cycle u, combinationally. State is IDLE at u+1. The earliest next grant is at u+2.
- A cache's write-back followed by its fetch therefore uses two grants, with ≥1 IDLE cycle between them. A pending request from the other cache wins that IDLE cycle.
- No requester is starved: with both ports continuously requesting, grants alternate 0,1,0,1.
- Reset asserted mid-grant: next cycle IDLE with all outputs at reset values. An in-flight memory transaction is abandoned; the memory model is reset by the same signal.

## Test plan
- Single requester: c0_bus_rd=1, addr=5'h0A; memory answers mem_done after 3 cycles with rdata=16'hBEEF → mem_rd=1, mem_addr=0A from the cycle after the request; c0_bus_done high exactly with mem_done; c0_bus_din=BEEF; c1_bus_done stays 0.
- Tie after reset: c0 wr (addr 03, dout 1234) and c1 rd (addr 11) raised in the same cycle → c0 granted first; mem_wr=1, wdata=1234. After its done, c1 is granted (mem_rd=1, addr=11) two cycles later.
- Fairness: both ports hold requests for 6 transactions, each done after 2 cycles → grant sequence 01,10,01,10,01,10; no done is ever routed to the non-owner.
- Write-back then fetch: c0 does wr then immediately rd after its done, while c1 requests during c0's wr → order c0-wr, c1, c0-rd.
- Watchdog: TIMEOUT=8, c1 rd, mem_done never comes → grant=10 for 8 cycles, then IDLE; timeout_err=1 and stays 1; c1_bus_done never pulses. A subsequent c0 request is still served normally.
- Reset mid-grant: assert reset during OWN0 with mem_rd high → next cycle all outputs 0, grant=00, timeout_err=0. After release, a tie grants c0.
